clock_bcd_core: RTL

CLOCK_BCD_CORE -- requirements
Module: clock_bcd_core

---
 rtl/clock_pkg.sv | 27 ++
 rtl/bcd_field_cnt.sv | 35 +++
 rtl/clock_bcd_core.sv | 119 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and BCD limits for the BCD time-of-day clock core.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MINU = 2'd2,
    SET_SECO = 2'd3
  } set_state_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX   = 8'h59;

  function automatic logic [7:0] bcd_to_12h(input logic [7:0] h);
    logic [7:0] r;
    r = h;
    if (h == 8'h00)      r = 8'h12;
    else if (h <= 8'h12) r = h;
    else if (h <= 8'h19) r = h - 8'h12;
    else if (h == 8'h20) r = 8'h08;
    else if (h == 8'h21) r = 8'h09;
    else if (h == 8'h22) r = 8'h10;
    else                 r = 8'h11;
    return r;
  endfunction

endpackage

// File: rtl/bcd_field_cnt.sv
// Two-digit BCD field counter with a programmable wrap limit.
module bcd_field_cnt
  import clock_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic [7:0] value,
  output logic [7:0] nxt,
  output logic       wrap
);

  assign wrap = inc && (value == limit);

  always_comb begin
    nxt = value;
    if (inc) begin
      if (value == limit)
        nxt = 8'h00;
      else if (value[3:0] == 4'd9)
        nxt = {value[7:4] + 4'd1, 4'd0};
      else
        nxt = {value[7:4], value[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value <= RST_VAL;
    else     value <= nxt;
  end

endmodule

// File: rtl/clock_bcd_core.sv
// BCD time-of-day clock with set FSM and 12h display.
// Optional alarm enabled by defining CLOCK_ALARM_EN.
module clock_bcd_core
  import clock_pkg::*;
#(
  parameter int         TICK_DIV  = 50_000_000,
  parameter logic [7:0] INIT_HOUR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       mode_12h,
  output logic [7:0] hour_bcd,
  output logic [7:0] minu_bcd,
  output logic [7:0] seco_bcd,
  output logic       pm,
  output logic       time_vld,
  output logic [1:0] set_state,
  input  logic [7:0] alarm_hour_bcd,
  input  logic [7:0] alarm_minu_bcd,
  input  logic       alarm_on,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PTOP = PW'(TICK_DIV - 1);

  set_state_e state_q, state_d;
  logic [PW-1:0] presc;
  logic [7:0] hour, minu, seco;
  logic [7:0] hour_nxt, minu_nxt, seco_nxt;
  logic hour_wrap, minu_wrap, seco_wrap;
  logic tick, edit;
  logic hour_inc, minu_inc, seco_inc;

  assign tick = (state_q == RUN) && (presc == PTOP);
  assign edit = key_inc && !key_mode;

  // Carries ride only on the prescaler tick; set-mode edits never carry.
  assign seco_inc = tick || (state_q == SET_SECO && edit);
  assign minu_inc = (tick && seco_wrap) || (state_q == SET_MINU && edit);
  assign hour_inc = (tick && seco_wrap && minu_wrap)
                 || (state_q == SET_HOUR && edit);

  always_comb begin
    state_d = state_q;
    if (key_mode) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MINU;
        SET_MINU: state_d = SET_SECO;
        default:  state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      presc    <= '0;
      time_vld <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_vld <= seco_inc || minu_inc || hour_inc;
      if (state_q != RUN || state_d != RUN || tick)
        presc <= '0;
      else
        presc <= presc + PW'(1);
    end
  end

  bcd_field_cnt #(.RST_VAL(INIT_HOUR)) u_hour (
    .clk(clk), .rst(rst), .inc(hour_inc), .limit(HOUR_MAX),
    .value(hour), .nxt(hour_nxt), .wrap(hour_wrap)
  );

  bcd_field_cnt #(.RST_VAL(8'h00)) u_minu (
    .clk(clk), .rst(rst), .inc(minu_inc), .limit(MS_MAX),
    .value(minu), .nxt(minu_nxt), .wrap(minu_wrap)
  );

  bcd_field_cnt #(.RST_VAL(8'h00)) u_seco (
    .clk(clk), .rst(rst), .inc(seco_inc), .limit(MS_MAX),
    .value(seco), .nxt(seco_nxt), .wrap(seco_wrap)
  );

  assign hour_bcd  = mode_12h ? bcd_to_12h(hour) : hour;
  assign pm        = mode_12h && (hour >= 8'h12);
  assign minu_bcd  = minu;
  assign seco_bcd  = seco;
  assign set_state = state_q;

`ifdef CLOCK_ALARM_EN
  logic alarm_q;
  logic unused_alarm;
  assign unused_alarm = ^{seco_nxt, hour_wrap};

  // Compare against the post-tick values so the flag rises with 00 seconds.
  always_ff @(posedge clk) begin
    if (rst)
      alarm_q <= 1'b0;
    else if (key_mode || key_inc || !alarm_on)
      alarm_q <= 1'b0;
    else if (tick && seco_wrap
             && hour_nxt == alarm_hour_bcd
             && minu_nxt == alarm_minu_bcd)
      alarm_q <= 1'b1;
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hour_bcd, alarm_minu_bcd, alarm_on,
                          hour_nxt, minu_nxt, seco_nxt, hour_wrap};
  assign alarm = 1'b0;
`endif

endmodule
